// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder.
//   - load/store func3 encodings
//   - responder FSM state type
//   - store helpers: byte-enable generation (zero when misaligned) and lane replication
package dmem_responder_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } dmem_state_t;

  // Byte enables for a store; an all-zero result means the store is dropped
  // (misaligned half or word). Unknown codes behave as a word store.
  function automatic logic [3:0] st_byte_en(input logic [2:0] func3,
                                            input logic [1:0] addr_lo);
    logic [3:0] be;
    case (func3)
      F3_SB:   be = 4'b0001 << addr_lo;
      F3_SH:   be = addr_lo[0] ? 4'b0000 : (addr_lo[1] ? 4'b1100 : 4'b0011);
      F3_SW:   be = (addr_lo == 2'b00) ? 4'b1111 : 4'b0000;
      default: be = (addr_lo == 2'b00) ? 4'b1111 : 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate right-aligned store data across all lanes so the byte enables
  // alone select what lands in the word.
  function automatic logic [31:0] st_lanes(input logic [2:0]  func3,
                                           input logic [31:0] data);
    logic [31:0] lanes;
    case (func3)
      F3_SB:   lanes = {4{data[7:0]}};
      F3_SH:   lanes = {2{data[15:0]}};
      default: lanes = data;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load data alignment: picks the byte/half addressed by addr[1:0] out of a
// 32-bit word, sign- or zero-extends it, and flags misaligned half/word loads.
// Ports:
//   i_word      32-bit word read from the array
//   i_addr_lo   load byte address bits [1:0]
//   i_func3     load width/sign code
//   o_data      extended load data (0 when misaligned)
//   o_misalign  misaligned load flag
module dmem_load_align
  import dmem_responder_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_func3,
  output logic [31:0] o_data,
  output logic        o_misalign
);

  // Bring the addressed byte/half down to bit 0. For aligned halves the shift
  // is 0 or 16; misaligned cases are zeroed below so the shift value is moot.
  logic [31:0] w_shifted;
  assign w_shifted = i_word >> {i_addr_lo, 3'b000};

  always_comb begin
    o_data     = '0;
    o_misalign = 1'b0;
    case (i_func3)
      F3_LB:  o_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_LBU: o_data = {24'h0, w_shifted[7:0]};
      F3_LH: begin
        o_misalign = i_addr_lo[0];
        o_data     = {{16{w_shifted[15]}}, w_shifted[15:0]};
      end
      F3_LHU: begin
        o_misalign = i_addr_lo[0];
        o_data     = {16'h0, w_shifted[15:0]};
      end
      F3_LW: begin
        o_misalign = |i_addr_lo;
        o_data     = i_word;
      end
      default: begin
        o_misalign = |i_addr_lo;
        o_data     = i_word;
      end
    endcase
    if (o_misalign) o_data = '0;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: memory-side end of the load/store interface.
// One load in flight at a time, answered after LOAD_LATENCY cycles with
// aligned, extended data; retired stores commit in one cycle with byte enables;
// a flush kills the in-flight load.
// Optional feature: define DMEM_PERF_CNT_EN to add o_ld_count / o_st_count.
// Ports:
//   i_clk, i_reset        clock, asynchronous active-high reset
//   i_ld_req/addr/func3   load request (single-cycle pulse), byte address, width code
//   i_st_req/addr/data/func3  store writeback from the LSQ (always accepted)
//   i_flush               kill the in-flight load
//   o_ld_ready            load can be accepted this cycle (combinational)
//   o_rd_valid            one-cycle response pulse
//   o_rd_data             extended load data
//   o_ld_misalign         qualifies o_rd_valid: misaligned load, data is 0
//   o_dbg_state           current FSM state (0 = IDLE, 1 = BUSY)
//   o_ld_count/o_st_count completed load / committed store counters (optional)
//
// Handshake: a load is accepted on a rising edge where i_ld_req && o_ld_ready;
// o_rd_valid is then high for exactly the cycle LOAD_LATENCY cycles after the
// accepting cycle. Stores have no ready and commit on the edge where i_st_req
// is high; a store in the same cycle as a load holds the load off.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS  = 256,
  parameter int LOAD_LATENCY = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_ld_req,
  input  logic [31:0] i_ld_addr,
  input  logic [2:0]  i_ld_func3,
  input  logic        i_st_req,
  input  logic [31:0] i_st_addr,
  input  logic [31:0] i_st_data,
  input  logic [2:0]  i_st_func3,
  input  logic        i_flush,
  output logic        o_ld_ready,
  output logic        o_rd_valid,
  output logic [31:0] o_rd_data,
  output logic        o_ld_misalign,
  output logic        o_dbg_state
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [31:0] o_ld_count,
  output logic [31:0] o_st_count
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LOAD_LATENCY > 1) ? $clog2(LOAD_LATENCY) : 1;

  logic [31:0]   r_mem [DEPTH_WORDS];
  dmem_state_t   r_state;
  logic [CW-1:0] r_count;
  logic [31:0]   r_hold_data;
  logic          r_hold_mis;

  logic [AW-1:0] w_ld_idx;
  logic [AW-1:0] w_st_idx;
  logic [31:0]   w_ld_word;
  logic [31:0]   w_al_data;
  logic          w_al_mis;
  logic          w_ld_accept;
  logic [3:0]    w_st_be;
  logic [31:0]   w_st_lanes;
  logic          w_st_commit;
  logic          w_unused;

  // Upper address bits are ignored, so addresses wrap modulo the array size.
  assign w_ld_idx = i_ld_addr[2 +: AW];
  assign w_st_idx = i_st_addr[2 +: AW];
  assign w_unused = ^{i_ld_addr[31:AW+2], i_st_addr[31:AW+2]};

  assign o_ld_ready  = (r_state == IDLE) && !i_st_req && !i_flush;
  assign w_ld_accept = i_ld_req && o_ld_ready;
  assign o_dbg_state = r_state;

  assign w_ld_word = r_mem[w_ld_idx];

  dmem_load_align u_align (
    .i_word     (w_ld_word),
    .i_addr_lo  (i_ld_addr[1:0]),
    .i_func3    (i_ld_func3),
    .o_data     (w_al_data),
    .o_misalign (w_al_mis)
  );

  assign w_st_be     = st_byte_en(i_st_func3, i_st_addr[1:0]);
  assign w_st_lanes  = st_lanes(i_st_func3, i_st_data);
  assign w_st_commit = i_st_req && (w_st_be != 4'b0000);

  // Array contents are not reset.
  always_ff @(posedge i_clk) begin
    if (w_st_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (w_st_be[b]) r_mem[w_st_idx][8*b +: 8] <= w_st_lanes[8*b +: 8];
      end
    end
  end

  // The aligned result is captured at acceptance, so a later store to the
  // same word does not affect an in-flight load. The response is registered
  // on the edge where the counter is about to reach 0, which puts rd_valid in
  // the cycle LOAD_LATENCY after acceptance with the FSM already back in IDLE
  // (allowing back-to-back loads).
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= IDLE;
      r_count       <= '0;
      r_hold_data   <= '0;
      r_hold_mis    <= 1'b0;
      o_rd_valid    <= 1'b0;
      o_rd_data     <= '0;
      o_ld_misalign <= 1'b0;
    end else begin
      o_rd_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_ld_accept) begin
            if (LOAD_LATENCY == 1) begin
              o_rd_valid    <= 1'b1;
              o_rd_data     <= w_al_data;
              o_ld_misalign <= w_al_mis;
            end else begin
              r_state     <= BUSY;
              r_count     <= CW'(LOAD_LATENCY - 1);
              r_hold_data <= w_al_data;
              r_hold_mis  <= w_al_mis;
            end
          end
        end
        BUSY: begin
          if (i_flush) begin
            r_state <= IDLE;
            r_count <= '0;
          end else begin
            r_count <= r_count - CW'(1);
            if (r_count == CW'(1)) begin
              r_state       <= IDLE;
              o_rd_valid    <= 1'b1;
              o_rd_data     <= r_hold_data;
              o_ld_misalign <= r_hold_mis;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef DMEM_PERF_CNT_EN
  // Flushed loads never raise rd_valid, so counting pulses excludes them.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_ld_count <= '0;
      o_st_count <= '0;
    end else begin
      if (o_rd_valid)  o_ld_count <= o_ld_count + 32'd1;
      if (w_st_commit) o_st_count <= o_st_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;
  localparam int W     = 33;   // {misalign, data}
  localparam int NB    = DEPTH * 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        i_reset = 1'b0;
  logic        i_ld_req = 1'b0;
  logic [31:0] i_ld_addr = '0;
  logic [2:0]  i_ld_func3 = '0;
  logic        i_st_req = 1'b0;
  logic [31:0] i_st_addr = '0;
  logic [31:0] i_st_data = '0;
  logic [2:0]  i_st_func3 = '0;
  logic        i_flush = 1'b0;
  logic        o_ld_ready;
  logic        o_rd_valid;
  logic [31:0] o_rd_data;
  logic        o_ld_misalign;
  logic        o_dbg_state;
`ifdef DMEM_PERF_CNT_EN
  logic [31:0] o_ld_count;
  logic [31:0] o_st_count;
`endif

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LOAD_LATENCY(LAT)) dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_ld_req      (i_ld_req),
    .i_ld_addr     (i_ld_addr),
    .i_ld_func3    (i_ld_func3),
    .i_st_req      (i_st_req),
    .i_st_addr     (i_st_addr),
    .i_st_data     (i_st_data),
    .i_st_func3    (i_st_func3),
    .i_flush       (i_flush),
    .o_ld_ready    (o_ld_ready),
    .o_rd_valid    (o_rd_valid),
    .o_rd_data     (o_rd_data),
    .o_ld_misalign (o_ld_misalign),
    .o_dbg_state   (o_dbg_state)
`ifdef DMEM_PERF_CNT_EN
    ,
    .o_ld_count    (o_ld_count),
    .o_st_count    (o_st_count)
`endif
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state / reference model ----------------
  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  logic [7:0]   ref_b [NB];
  bit           pending = 1'b0;
  int           resp_cyc = 0;
  int           m_ld_cnt = 0;
  int           m_st_cnt = 0;
  int           n_chk = 0;
  int           n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic int ld_size(input logic [2:0] f);
    case (f)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  // Byte-addressed model: the array is just NB bytes, address taken modulo NB.
  function automatic logic [W-1:0] model_load(input logic [31:0] a, input logic [2:0] f);
    int          sz;
    int          b;
    logic [31:0] v;
    sz = ld_size(f);
    b  = int'(a % NB);
    v  = 32'h0;
    if (a % sz != 0) return {1'b1, 32'h0};
    for (int i = 0; i < sz; i++) v = v | (32'(ref_b[b + i]) << (8 * i));
    if ((f == 3'd0 || f == 3'd1) && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
    return {1'b0, v};
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    int sz;
    int b;
    sz = (f == 3'd0) ? 1 : (f == 3'd1) ? 2 : 4;
    if (a % sz != 0) return;
    b = int'(a % NB);
    for (int i = 0; i < sz; i++) ref_b[b + i] = d[8*i +: 8];
    m_st_cnt++;
  endtask

  // ---------------- driver ----------------
  // One cycle of stimulus. The load response is taken from the model unless
  // use_k is set, in which case the caller's literal expectation is queued.
  task automatic drive(input bit ld, input logic [31:0] la, input logic [2:0] lf,
                       input bit st, input logic [31:0] sa, input logic [31:0] sd,
                       input logic [2:0] sf, input bit fl,
                       input bit use_k, input logic [W-1:0] k, output bit acc);
    bit exp_rdy;
    @(negedge clk);
    i_ld_req = ld; i_ld_addr = la; i_ld_func3 = lf;
    i_st_req = st; i_st_addr = sa; i_st_data = sd; i_st_func3 = sf;
    i_flush  = fl;
    #1;
    exp_rdy = (!pending || cyc >= resp_cyc) && !st && !fl;
    chk("ld_ready", 64'(o_ld_ready), 64'(exp_rdy));
    if (fl && pending && cyc < resp_cyc) begin
      pending = 1'b0;
      m_ld_cnt--;
      if (exp_q.size() > 0) begin
        void'(exp_q.pop_back());
        void'(exp_cyc_q.pop_back());
      end
    end
    acc = ld && exp_rdy;
    if (acc) begin
      exp_q.push_back(use_k ? k : model_load(la, lf));
      exp_cyc_q.push_back(cyc + LAT);
      pending  = 1'b1;
      resp_cyc = cyc + LAT;
      m_ld_cnt++;
    end
    if (st) model_store(sa, sd, sf);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, '0, acc);
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    bit acc;
    drive(0, 0, 0, 1, a, d, f, 0, 0, '0, acc);
  endtask

  task automatic do_load(input logic [31:0] a, input logic [2:0] f,
                         input bit use_k, input logic [W-1:0] k);
    bit acc;
    acc = 1'b0;
    for (int t = 0; t < 20 && !acc; t++) drive(1, a, f, 0, 0, 0, 0, 0, use_k, k, acc);
    if (!acc) begin
      n_chk++;
      $display("FAIL load_accept_timeout: addr %0h not accepted within 20 cycles", a);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_ld_req = 0; i_st_req = 0; i_flush = 0;
    i_reset  = 1'b1;
    exp_q.delete();
    exp_cyc_q.delete();
    pending  = 1'b0;
    m_ld_cnt = 0;
    m_st_cnt = 0;
    #1;
    chk("reset_rd_valid", 64'(o_rd_valid), 64'(0));
    chk("reset_rd_data", 64'(o_rd_data), 64'(0));
    chk("reset_misalign", 64'(o_ld_misalign), 64'(0));
    chk("reset_state", 64'(o_dbg_state), 64'(0));
    chk("reset_ld_ready", 64'(o_ld_ready), 64'(1));
    @(negedge clk);
    i_reset = 1'b0;
  endtask

  // ---------------- monitor ----------------
  logic [W-1:0] mon_e;
  int           mon_c;
  always @(posedge clk) begin
    #1;
    if (!i_reset) begin
      while (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
        n_chk++;
        $display("FAIL missing_rd_valid: expected at cycle %0d, still absent at cycle %0d", exp_cyc_q[0], cyc);
        void'(exp_q.pop_front());
        void'(exp_cyc_q.pop_front());
      end
      if (o_rd_valid) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_rd_valid: data %0h at cycle %0d, nothing expected", o_rd_data, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          mon_c = exp_cyc_q.pop_front();
          chk("rd_cycle", 64'(cyc), 64'(mon_c));
          chk("rd_data", 64'(o_rd_data), 64'(mon_e[31:0]));
          chk("ld_misalign", 64'(o_ld_misalign), 64'(mon_e[32]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit          acc;
    logic [31:0] r_a;
    logic [31:0] r_s;
    int          sel;

    do_reset();

    // basic latency: SW then LW two cycles later
    do_store(32'h40, 32'hDEAD_BEEF, 3'b010);
    idle(1);
    do_load(32'h40, 3'b010, 1, {1'b0, 32'hDEAD_BEEF});
    idle(3);

    // extension cases
    do_store(32'h10, 32'h80FF_7F01, 3'b010);
    do_load(32'h13, 3'b000, 1, {1'b0, 32'hFFFF_FF80});
    do_load(32'h13, 3'b100, 1, {1'b0, 32'h0000_0080});
    do_load(32'h12, 3'b001, 1, {1'b0, 32'hFFFF_80FF});
    do_load(32'h10, 3'b101, 1, {1'b0, 32'h0000_7F01});
    idle(3);

    // byte store merge, dropped misaligned half store
    do_store(32'h20, 32'h1122_3344, 3'b010);
    do_store(32'h21, 32'h0000_00AA, 3'b000);
    do_load(32'h20, 3'b010, 1, {1'b0, 32'h1122_AA44});
    idle(2);
    do_store(32'h21, 32'h0000_BEEF, 3'b001);
    do_load(32'h20, 3'b010, 1, {1'b0, 32'h1122_AA44});
    idle(2);

    // misaligned word load
    do_load(32'h22, 3'b010, 1, {1'b1, 32'h0});
    idle(3);

    // flush one cycle after acceptance: no response, ready again next cycle
    do_load(32'h40, 3'b010, 0, '0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, '0, acc);
    idle(4);

    // load and store together: store wins, load held off
    drive(1, 32'h40, 3'b010, 1, 32'h44, 32'h1234_5678, 3'b010, 0, 0, '0, acc);
    do_load(32'h44, 3'b010, 1, {1'b0, 32'h1234_5678});
    idle(3);

    // flush in the rd_valid cycle does not cancel the pulse
    do_load(32'h10, 3'b010, 1, {1'b0, 32'h80FF_7F01});
    idle(1);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, '0, acc);
    idle(3);

    // store during load latency is not visible to that load
    do_load(32'h40, 3'b010, 1, {1'b0, 32'hDEAD_BEEF});
    do_store(32'h40, 32'h0BAD_F00D, 3'b010);
    idle(3);

    // reset while a load is in flight: no response
    do_load(32'h10, 3'b010, 0, '0);
    do_reset();
    idle(4);

    // address wrap, counters from fresh reset
    do_store(32'h400, 32'h5A5A_5A5A, 3'b010);
    do_load(32'h000, 3'b010, 1, {1'b0, 32'h5A5A_5A5A});
    idle(4);
`ifdef DMEM_PERF_CNT_EN
    chk("ld_count_wrap", 64'(o_ld_count), 64'(1));
    chk("st_count_wrap", 64'(o_st_count), 64'(1));
`endif

    // fill every word so the model knows the whole array, then random traffic
    for (int i = 0; i < DEPTH; i++) begin
      r_s = $urandom;
      r_a = $urandom;
      r_a[AW_HI():0] = 10'(i * 4);
      do_store(r_a, r_s, 3'b010);
    end
    for (int n = 0; n < 1500; n++) begin
      r_a = $urandom;
      sel = $urandom_range(0, 3);
      if (sel == 1) r_a[1:0] = 2'b00;
      if (sel == 2) r_a[0] = 1'b0;
      r_s = $urandom;
      drive($urandom_range(0, 1) == 1, r_a, 3'($urandom_range(0, 7)),
            $urandom_range(0, 3) == 0, $urandom, r_s, 3'($urandom_range(0, 7)),
            $urandom_range(0, 9) == 0, 0, '0, acc);
    end

    for (int t = 0; t < 20 && exp_q.size() > 0; t++) idle(1);
    idle(2);
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
`ifdef DMEM_PERF_CNT_EN
    chk("ld_count_final", 64'(o_ld_count), 64'(m_ld_cnt));
    chk("st_count_final", 64'(o_st_count), 64'(m_st_cnt));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Top bit of the in-array byte offset (NB = 1024 bytes -> bit 9).
  function automatic int AW_HI();
    return 9;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the memory-side end of the load/store interface driven by the memory functional unit and the LSQ.
- Accepts one load request at a time and returns aligned, sign/zero-extended data after a fixed, parameterised latency.
- Commits retired stores from the LSQ in a single cycle with byte enables.
- Supports mispredict flush of an in-flight load.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the array (power of two).
- LOAD_LATENCY, 2, cycles from load acceptance to rd_valid (must be >= 1).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- ld_req  in  1  load request, single-cycle pulse
- ld_addr  in  32  load byte address
- ld_func3  in  3  load width/sign code
- st_req  in  1  retired-store writeback request from LSQ
- st_addr  in  32  store byte address
- st_data  in  32  store data, right-aligned
- st_func3  in  3  store width code
- flush  in  1  mispredict kill of the in-flight load
- ld_ready  out  1  load can be accepted this cycle
- rd_valid  out  1  load response valid, one-cycle pulse
- rd_data  out  32  extended load data
- ld_misalign  out  1  qualifies rd_valid: misaligned load, rd_data = 0

Behaviour:
- Reset: state=IDLE, counter=0, rd_valid=0, rd_data=0, ld_misalign=0. Array contents are not reset.
- Word index = addr[2 +: log2(DEPTH_WORDS)]. Upper address bits are ignored, so addresses wrap modulo the array size.
- ld_ready = (state==IDLE) && !st_req && !flush. This is combinational.
- Load acceptance: ld_req && ld_ready at cycle T.
  - The word is read and the address/func3 are captured at T.
  - rd_valid is high for exactly cycle T+LOAD_LATENCY.
- FSM:
  - IDLE -> BUSY on acceptance; counter = LOAD_LATENCY-1.
  - BUSY decrements the counter each cycle.
  - BUSY with counter==0 -> IDLE, with rd_valid/rd_data registered.
  - With LOAD_LATENCY=1, the FSM goes directly IDLE -> IDLE with rd_valid at T+1.
  - A new load can be accepted in the cycle rd_valid is high.
- Load func3 decoding:
  - 000 LB: sign-extend byte at addr[1:0].
  - 001 LH: sign-extend half at addr[1].
  - 010 LW.
  - 100 LBU, 101 LHU: zero-extend.
  - Other func3 codes: treated as LW.
- Load misalignment (LH/LHU with addr[0]=1, LW with addr[1:0]!=0): the response still arrives at latency, with rd_data=0 and ld_misalign=1.
- Stores: when st_req is high, the write happens at the clock edge (st_ready is implicitly always 1).
  - SB writes byte addr[1:0] with st_data[7:0].
  - SH writes half addr[1] with st_data[15:0].
  - SW writes the full word.
  - Misaligned stores are dropped silently.
  - Other func3 codes are treated as SW.
- Store priority: a store has priority over a load in the same cycle; the load is held off by ld_ready=0.
- Read-after-write: a store to the same word in a later cycle, during the load's latency, is NOT visible to that load, because data was captured at acceptance.
- Flush:
  - In BUSY: -> IDLE next cycle, with no rd_valid for that load.
  - Flush in the same cycle as ld_req: the load is not accepted.
  - Flush in the rd_valid cycle has no effect on the pulse already being driven.
  - Stores are never flushed.
- Reset mid-load: the in-flight load is discarded immediately and no response is produced.

Optional Feature:
DMEM_PERF_CNT_EN
- Defined: adds outputs ld_count[31:0] and st_count[31:0].
  - ld_count increments on each rd_valid, excluding flushed loads.
  - st_count increments on each committed, non-dropped store.
  - Both counters wrap at 2^32 and reset to 0.
- Undefined: no counter ports or logic.

Decomposition:
- types_pkg holds:
  - func3 localparams F3_LB/LH/LW/LBU/LHU and F3_SB/SH/SW.
  - enum dmem_state_t {IDLE, BUSY}.
- Sub-module dmem_load_align: combinational byte/half select plus extension and misalign detect. Inputs: word, addr[1:0], func3. Outputs: data, misalign.

Test Plan:
- LOAD_LATENCY=2: SW 0xDEADBEEF @0x40 at cycle 0; LW @0x40 accepted at cycle 2 -> rd_valid only at cycle 4, rd_data=0xDEADBEEF.
- Byte/half extension: word 0x80FF7F01 @0x10.
  - LB @0x13 -> 0xFFFFFF80.
  - LBU @0x13 -> 0x00000080.
  - LH @0x12 -> 0xFFFF80FF.
  - LHU @0x10 -> 0x00007F01.
- SB 0xAA @0x21 over word 0x11223344 -> LW @0x20 returns 0x1122AA44. SH @0x21 is dropped, so the word is unchanged.
- Misaligned load: LW @0x22 -> rd_valid at latency, rd_data=0, ld_misalign=1.
- Flush: load accepted at T, flush at T+1 -> no rd_valid at T+2, ld_ready=1 at T+2. Separately, ld_req+st_req in the same cycle -> ld_ready=0 and the store commits.
- Wrap: with DEPTH_WORDS=256, SW 0x5A5A5A5A @0x400 -> LW @0x000 returns 0x5A5A5A5A. With DMEM_PERF_CNT_EN defined, after the sequence ld_count=1 and st_count=1.
